// File: rtl/spi_sclk_gen.sv
// SPI master serial-clock and timing generator.
// Produces SCLK with a runtime half-period, frame length and CPOL/CPHA mode, together with
// registered edge, sample and shift strobes and an end-of-frame ready pulse.
module spi_sclk_gen #(
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned BITS_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic [DIV_W-1:0]  i_half_div,
  input  logic [BITS_W-1:0] i_num_bits,
  input  logic              i_tx_valid,
  input  logic              i_abort,
  output logic              out_clk,
  output logic              o_busy,
  output logic              o_tx_rdy,
  output logic              o_leading_edge,
  output logic              o_trailing_edge,
  output logic              o_sample,
  output logic              o_shift
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic              cpol_q;
  logic              cpha_q;
  // Half-period minus one; a divider of 0 behaves like 1.
  logic [DIV_W-1:0]  hm1_q;
  logic [DIV_W-1:0]  hc_q;
  // Frame length minus one; a length of 0 wraps to 2**BITS_W - 1, i.e. a full-size frame.
  logic [BITS_W-1:0] nm1_q;
  // Toggles already issued in this frame. Holds at most 2N-1, so BITS_W+1 bits never wrap.
  logic [BITS_W:0]   ecnt_q;

  logic toggle_now;
  logic leading_now;
  logic last_now;

  // Decode the upcoming toggle: due, leading or trailing, and whether it ends the frame.
  always_comb begin
    toggle_now  = (hc_q == hm1_q);
    leading_now = ~ecnt_q[0];
    last_now    = (ecnt_q == {nm1_q, 1'b1});
  end

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= StIdle;
      cpol_q          <= 1'b0;
      cpha_q          <= 1'b0;
      hm1_q           <= '0;
      hc_q            <= '0;
      nm1_q           <= '0;
      ecnt_q          <= '0;
      out_clk         <= 1'b0;
      o_busy          <= 1'b0;
      o_tx_rdy        <= 1'b0;
      o_leading_edge  <= 1'b0;
      o_trailing_edge <= 1'b0;
      o_sample        <= 1'b0;
      o_shift         <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      o_tx_rdy        <= 1'b0;
      o_leading_edge  <= 1'b0;
      o_trailing_edge <= 1'b0;
      o_sample        <= 1'b0;
      o_shift         <= 1'b0;

      unique case (state_q)
        StIdle: begin
          out_clk <= i_cpol;
          o_busy  <= 1'b0;
          if (i_tx_valid) begin
            cpol_q  <= i_cpol;
            cpha_q  <= i_cpha;
            hm1_q   <= (i_half_div == '0) ? '0 : i_half_div - DIV_W'(1);
            nm1_q   <= i_num_bits - BITS_W'(1);
            hc_q    <= '0;
            ecnt_q  <= '0;
            o_busy  <= 1'b1;
            state_q <= StRun;
          end
        end

        StRun: begin
          if (i_abort) begin
            // Abort takes priority over any toggle due this cycle.
            out_clk <= cpol_q;
            o_busy  <= 1'b0;
            hc_q    <= '0;
            ecnt_q  <= '0;
            state_q <= StIdle;
          end else if (toggle_now) begin
            hc_q    <= '0;
            out_clk <= ~out_clk;
            ecnt_q  <= ecnt_q + (BITS_W+1)'(1);
            if (leading_now) begin
              o_leading_edge <= 1'b1;
              if (cpha_q) o_shift  <= 1'b1;
              else        o_sample <= 1'b1;
            end else begin
              o_trailing_edge <= 1'b1;
              if (cpha_q)         o_sample <= 1'b1;
              else if (!last_now) o_shift  <= 1'b1;
            end
            if (last_now) begin
              ecnt_q   <= '0;
              o_busy   <= 1'b0;
              o_tx_rdy <= 1'b1;
              state_q  <= StDone;
            end
          end else begin
            hc_q <= hc_q + DIV_W'(1);
          end
        end

        StDone: begin
          // One dead cycle guarantees the inter-frame gap; requests are not queued.
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
